// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory and its byte-serial program loader.
package inst_mem_pkg;

    localparam int INST_ADDR_W = 17;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } load_state_e;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read-first read port, no reset on the array.
module bram_sdp #(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Non-blocking read of the old word gives read-first on an address collision.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a one-cycle registered read and a UART-fed program loader
// (4-byte big-endian word count, then that many big-endian words).
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int          ADDR_W   = INST_ADDR_W,
    parameter logic [31:0] LOAD_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_data,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    load_state_e       state;
    logic [23:0]       shreg;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   last_idx;
    logic [31:0]       word_in;
    logic              word_end;
    logic              we;
    logic [31:0]       rdata;
    logic              done_q;
    logic              rst_q;

    assign word_in  = {shreg, rx_data};
    assign word_end = rx_valid && (byte_cnt == 2'd3);
    assign last_idx = n_words - {{ADDR_W{1'b0}}, 1'b1};
    assign we       = (state == BODY) && word_end;

    bram_sdp #(.AW(ADDR_W), .DW(32)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (word_in),
        .raddr (inst_addr),
        .rdata (rdata)
    );

    // RAM output stays unreset for BRAM inference; the mux selectors are registered instead.
    assign inst_data = rst_q ? 32'h0 : (done_q ? rdata : LOAD_VAL);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= HDR;
            shreg     <= '0;
            byte_cnt  <= 2'd0;
            wr_ptr    <= '0;
            n_words   <= '0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            done_q    <= 1'b0;
            rst_q     <= 1'b1;
        end else begin
            rst_q  <= 1'b0;
            done_q <= (state == DONE);
            case (state)
                HDR: begin
                    load_busy <= 1'b1;
                    if (rx_valid) begin
                        shreg    <= word_in[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    if (word_end) begin
                        if (word_in == 32'h0) begin
                            state     <= DONE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end else if ({1'b0, word_in} > DEPTH) begin
                            state     <= ERR;
                            load_busy <= 1'b0;
                            load_err  <= 1'b1;
                        end else begin
                            n_words <= word_in[ADDR_W:0];
                            state   <= BODY;
                        end
                    end
                end
                BODY: begin
                    load_busy <= 1'b1;
                    if (rx_valid) begin
                        shreg    <= word_in[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    if (word_end) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if ({1'b0, wr_ptr} == last_idx) begin
                            state     <= DONE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    load_busy <= 1'b0;
                    load_done <= 1'b1;
                end
                default: begin
                    load_busy <= 1'b0;
                    load_err  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem: the driver queues expected reads/flags, a negedge monitor checks them.
module tb_inst_mem;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [31:0]   inst_data;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          load_busy, load_done, load_err;

    inst_mem #(.ADDR_W(AW), .LOAD_VAL(32'h0000_0000)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          kind;   // 0: inst_data, 1: {busy,done,err}
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   req_n = 0;
    int   pend_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] words [64];

    // Items requested in a driver slot are due at the negedge after that slot's posedge.
    always @(posedge clk) pend_n <= req_n;

    always @(negedge clk) begin : monitor
        chk_t c;
        logic [31:0] got;
        for (int i = 0; i < pend_n; i++) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow got empty queue required an entry");
            end else begin
                c = exp_q.pop_front();
                got = c.kind ? {29'h0, load_busy, load_done, load_err} : inst_data;
                if (got !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s got %h required %h", c.name, got, c.exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        rx_valid = 1'b0;
        req_n = 0;
    endtask

    task automatic push(input bit kind, input string name, input logic [31:0] exp);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.exp  = exp;
        exp_q.push_back(c);
        req_n++;
    endtask

    task automatic exp_flags(input string name, input bit b, input bit d, input bit e);
        push(1'b1, name, {29'h0, b, d, e});
    endtask

    task automatic exp_data(input string name, input logic [AW-1:0] a, input logic [31:0] v);
        inst_addr = a;
        push(1'b0, name, v);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_reset(input string name);
        tick();
        rstn = 1'b0;
        exp_flags({name, "_rst_flags"}, 1'b0, 1'b0, 1'b0);
        exp_data({name, "_rst_data"}, '0, 32'h0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin : driver
        repeat (2) tick();

        // 1: two-word load and readback
        do_reset("t1");
        send_word(32'h0000_0002, 0);
        exp_flags("t1_hdr_busy", 1'b1, 1'b0, 1'b0);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        exp_flags("t1_pre_done", 1'b1, 1'b0, 1'b0);
        send_byte(8'h20, 0);
        exp_flags("t1_done", 1'b0, 1'b1, 1'b0);
        tick(); exp_data("t1_rd0", 0, 32'hDEAD_BEEF);
        tick(); exp_data("t1_rd1", 1, 32'h0000_0020);

        // 2: empty program keeps old contents
        do_reset("t2");
        send_word(32'h0000_0000, 0);
        exp_flags("t2_done", 1'b0, 1'b1, 1'b0);
        tick(); exp_data("t2_rd0", 0, 32'hDEAD_BEEF);
        tick(); exp_data("t2_rd1", 1, 32'h0000_0020);

        // 3: oversize count, then trailing bytes must not write
        do_reset("t3");
        send_word(32'h0002_0001, 0);
        exp_flags("t3_err", 1'b0, 1'b0, 1'b1);
        send_word(32'h1122_3344, 0);
        exp_flags("t3_err_hold", 1'b0, 1'b0, 1'b1);
        tick(); exp_data("t3_data0", 0, 32'h0);
        do_reset("t3b");
        send_word(32'h0000_0000, 0);
        tick(); exp_data("t3_nowrite", 0, 32'hDEAD_BEEF);

        // Boundary: N == depth is accepted
        do_reset("tb");
        send_word(32'h0002_0000, 0);
        exp_flags("tb_depth_ok", 1'b1, 1'b0, 1'b0);

        // 4: reading the word being written returns LOAD_VAL until DONE
        do_reset("t4");
        send_word(32'h0000_0001, 0);
        send_byte(8'hCA, 0); exp_data("t4_b0", 0, 32'h0);
        send_byte(8'hFE, 0); exp_data("t4_b1", 0, 32'h0);
        send_byte(8'hF0, 0); exp_data("t4_b2", 0, 32'h0);
        send_byte(8'h0D, 0); exp_data("t4_b3", 0, 32'h0);
        exp_flags("t4_done", 1'b0, 1'b1, 1'b0);
        tick(); exp_data("t4_rd0", 0, 32'hCAFE_F00D);

        // 5: reset mid-load restarts at the header
        do_reset("t5");
        send_word(32'h0000_0001, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        do_reset("t5_abort");
        send_word(32'h0000_0001, 0);
        send_word(32'h1234_5678, 0);
        exp_flags("t5_done", 1'b0, 1'b1, 1'b0);
        tick(); exp_data("t5_rd0", 0, 32'h1234_5678);

        // 6: 64 words with random inter-byte gaps, then back-to-back readback
        for (int i = 0; i < 64; i++)
            words[i] = (32'h0101_0101 * i) ^ 32'hA5C3_0F00;
        do_reset("t6");
        send_word(32'h0000_0040, $urandom_range(0, 20));
        for (int i = 0; i < 64; i++) begin
            for (int b = 3; b >= 0; b--)
                send_byte(words[i][8*b +: 8], $urandom_range(0, 20));
            if (i == 62)
                exp_flags("t6_busy", 1'b1, 1'b0, 1'b0);
        end
        exp_flags("t6_done", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_data($sformatf("t6_rd%0d", i), AW'(i), words[i]);
        end
        tick(); exp_data("t6_rd_rev", 5, words[5]);
        tick(); exp_data("t6_rd_rev2", 3, words[3]);

        repeat (3) tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
